agex_stage: RTL and testbench
=============================

// Module: agex_stage
// PURPOSE
//  ALU/address/branch-execute stage of the 5-stage RV32 pipeline. Consumes the decode latch (DE_latch_out) and computes ALU results, load/store addresses and branch outcomes.
//  Registers results into AGEX_latch for MEM.
//  Returns hazard/flush info to decode (from_AGEX_to_DE) and the redirect to fetch (from_AGEX_to_FE).
// PARAMETERS
//  MUL_STEPS  32  iterations of the shift-add multiplier (used only with AGEX_MUL_ITERATIVE_EN)
// PORTS
//  clk               in   1                       pipeline clock, all state on posedge
//  reset             in   1                       synchronous, active-high
//  from_DE_latch     in   `DE_latch_WIDTH         {inst,PC,pcplus,op_I,inst_count,regval1,regval2,sxt_imm,rd,wr_reg,type_I,bus_canary}
//  from_AGEX_to_DE   out  `from_AGEX_to_DE_WIDTH  {rd_AGEX[`REGNOBITS], type_I_AGEX[`TYPENOBITS], br_cond_AGEX, busy_AGEX}
//  from_AGEX_to_FE   out  `from_AGEX_to_FE_WIDTH  {br_cond_AGEX, br_target_AGEX[`DBITS]}
//  AGEX_latch_out    out  `AGEX_latch_WIDTH       {inst,PC,op_I,inst_count,aluout,st_data,rd,wr_reg,type_I,bus_canary}
// BEHAVIOUR
//  - Reset (sync): AGEX_latch=0, FSM=IDLE, step counter=0; all outputs 0 in the same cycle.
//  - Bubble: inst==0 or op_I==`INVALID_I -> br_cond=0, rd_AGEX=0, next latch all-zero.
//  - Latency 1 cycle: the input present before posedge N appears on AGEX_latch_out after N.
//  - aluout (32b, wrap-around arithmetic):
//      ADD/ADDI: a+b; SUB: a-b; AND/OR/XOR(+I): bitwise
//      SLT/SLTI: signed <; SLTU/SLTIU: unsigned <
//      SLL/SRL/SRA(+I): shift amount = b[4:0]; SRA arithmetic
//      MUL: low 32 bits of a*b
//      LUI: imm; AUIPC: PC+imm
//      LW/SW: regval1+imm (address)
//      JAL/JALR: pcplus
//      CSRR/CSRW: regval1
//    a=regval1; b=regval2 for R_Type, else sxt_imm. st_data=regval2.
//  - Branches: BEQ/BNE/BLT/BGE (signed), BLTU/BGEU (unsigned) compare regval1 and regval2.
//      Taken -> br_cond=1, target=PC+imm.
//      JAL: br_cond=1, target=PC+imm. JALR: br_cond=1, target=(regval1+imm)&~1.
//  - br_cond/br_target are combinational from from_DE_latch. FE redirects and DE flushes at the next posedge.
//    The branch itself is still latched into AGEX_latch.
//  - rd_AGEX = wr_reg ? rd : 0; type_I_AGEX = type_I of the current input. DE stalls on a match with rd!=0.
//  - busy_AGEX: see CONFIGURATION; while high, DE holds from_DE_latch stable and FE holds.
// CONFIGURATION
//  AGEX_MUL_ITERATIVE_EN undefined:
//    - MUL is single-cycle combinational; busy_AGEX tied 0; no FSM.
//  AGEX_MUL_ITERATIVE_EN defined: FSM IDLE->RUN->DONE->IDLE.
//    IDLE:
//      - Valid MUL at input -> load multiplicand/multiplier, clear accumulator, cnt=0, go RUN.
//      - busy=1 from this cycle; latch gets a bubble.
//    RUN:
//      - Per cycle: if mplier[0], acc+=mcand; mcand<<=1; mplier>>=1; cnt++.
//      - cnt==MUL_STEPS-1 -> DONE. busy=1, latch bubble, br_cond=0, rd_AGEX=MUL rd.
//    DONE:
//      - busy=0; latch captures the MUL with aluout=acc; -> IDLE.
//    Non-MUL ops are unaffected. Reset in any state -> IDLE, acc=0, latch=0.
//    MUL at input in DONE is the same instruction and is not restarted.
// TESTING
//  1 ADD rd=5, rs1=7, rs2=0xFFFFFFFB -> next cycle aluout=2, rd=5, wr_reg=1; rd_AGEX=5 during the input cycle.
//  2 BLT PC=0x100, imm=-16, a=-1, b=1 -> br_cond=1, target=0xF0. BLTU with the same operands -> br_cond=0.
//  3 JALR PC=0x40, pcplus=0x44, regval1=0x203, imm=0 -> target=0x202, aluout=0x44, br_cond=1.
//  4 Input inst=0 for 3 cycles -> latch all-zero, br_cond=0, rd_AGEX=0 throughout.
//  5 EN on: MUL 0x0001_0003 * 0x0000_0005 held stable -> busy=1 for MUL_STEPS+1 cycles, then latch aluout=0x0005_000F.
//    EN off: same result after 1 cycle.
//  6 EN on: assert reset at RUN cnt=10 -> next cycle busy=0, latch=0; a fresh MUL 7*6 gives 42.

Source files
------------

// File: rtl/agex_stage.sv
// agex_stage: ALU / address / branch execute stage of the 5-stage RV32 pipeline.
// Consumes the decode latch, resolves branches combinationally toward FE/DE and
// registers the ALU result into AGEX_latch for MEM (one cycle of latency).
// Build macro AGEX_MUL_ITERATIVE_EN: when defined, MUL runs on a multi-cycle
// shift-add engine with busy back-pressure; otherwise MUL is one combinational multiply.

`ifndef AGEX_DEFS
`define AGEX_DEFS
`define DBITS       32
`define INSTBITS    32
`define CNTBITS     32
`define REGNOBITS   5
`define TYPENOBITS  3
`define OPNOBITS    6
`define CANARYBITS  4
`define DE_latch_WIDTH (`INSTBITS + 2*`DBITS + `OPNOBITS + `CNTBITS + 3*`DBITS + `REGNOBITS + 1 + `TYPENOBITS + `CANARYBITS)
`define AGEX_latch_WIDTH (`INSTBITS + `DBITS + `OPNOBITS + `CNTBITS + 2*`DBITS + `REGNOBITS + 1 + `TYPENOBITS + `CANARYBITS)
`define from_AGEX_to_DE_WIDTH (`REGNOBITS + `TYPENOBITS + 2)
`define from_AGEX_to_FE_WIDTH (1 + `DBITS)
`define INVALID_I 6'd0
`define ADD_I     6'd1
`define ADDI_I    6'd2
`define SUB_I     6'd3
`define AND_I     6'd4
`define ANDI_I    6'd5
`define OR_I      6'd6
`define ORI_I     6'd7
`define XOR_I     6'd8
`define XORI_I    6'd9
`define SLT_I     6'd10
`define SLTI_I    6'd11
`define SLTU_I    6'd12
`define SLTIU_I   6'd13
`define SLL_I     6'd14
`define SLLI_I    6'd15
`define SRL_I     6'd16
`define SRLI_I    6'd17
`define SRA_I     6'd18
`define SRAI_I    6'd19
`define MUL_I     6'd20
`define LUI_I     6'd21
`define AUIPC_I   6'd22
`define LW_I      6'd23
`define SW_I      6'd24
`define JAL_I     6'd25
`define JALR_I    6'd26
`define BEQ_I     6'd27
`define BNE_I     6'd28
`define BLT_I     6'd29
`define BGE_I     6'd30
`define BLTU_I    6'd31
`define BGEU_I    6'd32
`define CSRR_I    6'd33
`define CSRW_I    6'd34
`define R_TYPE    3'd1
`define I_TYPE    3'd2
`define S_TYPE    3'd3
`define B_TYPE    3'd4
`define U_TYPE    3'd5
`define J_TYPE    3'd6
`endif

module agex_stage #(
  parameter int unsigned MUL_STEPS = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [`DE_latch_WIDTH-1:0]        from_DE_latch,
  output logic [`from_AGEX_to_DE_WIDTH-1:0] from_AGEX_to_DE,
  output logic [`from_AGEX_to_FE_WIDTH-1:0] from_AGEX_to_FE,
  output logic [`AGEX_latch_WIDTH-1:0]      AGEX_latch_out
);

  typedef struct packed {
    logic [`INSTBITS-1:0]   inst;
    logic [`DBITS-1:0]      pc;
    logic [`DBITS-1:0]      pcplus;
    logic [`OPNOBITS-1:0]   op_i;
    logic [`CNTBITS-1:0]    inst_count;
    logic [`DBITS-1:0]      regval1;
    logic [`DBITS-1:0]      regval2;
    logic [`DBITS-1:0]      sxt_imm;
    logic [`REGNOBITS-1:0]  rd;
    logic                   wr_reg;
    logic [`TYPENOBITS-1:0] type_i;
    logic [`CANARYBITS-1:0] bus_canary;
  } de_latch_t;

  typedef struct packed {
    logic [`INSTBITS-1:0]   inst;
    logic [`DBITS-1:0]      pc;
    logic [`OPNOBITS-1:0]   op_i;
    logic [`CNTBITS-1:0]    inst_count;
    logic [`DBITS-1:0]      aluout;
    logic [`DBITS-1:0]      st_data;
    logic [`REGNOBITS-1:0]  rd;
    logic                   wr_reg;
    logic [`TYPENOBITS-1:0] type_i;
    logic [`CANARYBITS-1:0] bus_canary;
  } agex_latch_t;

  if (MUL_STEPS == 0) begin : g_bad_mul_steps
    $error("MUL_STEPS must be nonzero");
  end

  de_latch_t             de;
  agex_latch_t           latch_q, latch_d;
  logic                  bubble, is_mul, mul_pending, busy;
  logic                  br_taken, br_cond;
  logic [`DBITS-1:0]     a, b, aluout, br_target, mul_res;
  logic [`REGNOBITS-1:0] rd_agex;

  assign de     = from_DE_latch;
  assign bubble = (de.inst == '0) || (de.op_i == `INVALID_I);
  assign is_mul = !bubble && (de.op_i == `MUL_I);
  assign a      = de.regval1;
  assign b      = (de.type_i == `R_TYPE) ? de.regval2 : de.sxt_imm;

  // ALU result selection
  always_comb begin
    aluout = '0;
    case (de.op_i)
      `ADD_I, `ADDI_I:   aluout = a + b;
      `SUB_I:            aluout = a - b;
      `AND_I, `ANDI_I:   aluout = a & b;
      `OR_I, `ORI_I:     aluout = a | b;
      `XOR_I, `XORI_I:   aluout = a ^ b;
      `SLT_I, `SLTI_I:   aluout = {31'd0, $signed(a) < $signed(b)};
      `SLTU_I, `SLTIU_I: aluout = {31'd0, a < b};
      `SLL_I, `SLLI_I:   aluout = a << b[4:0];
      `SRL_I, `SRLI_I:   aluout = a >> b[4:0];
      `SRA_I, `SRAI_I:   aluout = $unsigned($signed(a) >>> b[4:0]);
      `MUL_I:            aluout = mul_res;
      `LUI_I:            aluout = de.sxt_imm;
      `AUIPC_I:          aluout = de.pc + de.sxt_imm;
      `LW_I, `SW_I:      aluout = de.regval1 + de.sxt_imm;
      `JAL_I, `JALR_I:   aluout = de.pcplus;
      `CSRR_I, `CSRW_I:  aluout = de.regval1;
      default:           aluout = '0;
    endcase
  end

  // Branch / jump resolution
  always_comb begin
    br_taken  = 1'b0;
    br_target = de.pc + de.sxt_imm;
    case (de.op_i)
      `BEQ_I:  br_taken = de.regval1 == de.regval2;
      `BNE_I:  br_taken = de.regval1 != de.regval2;
      `BLT_I:  br_taken = $signed(de.regval1) < $signed(de.regval2);
      `BGE_I:  br_taken = $signed(de.regval1) >= $signed(de.regval2);
      `BLTU_I: br_taken = de.regval1 < de.regval2;
      `BGEU_I: br_taken = de.regval1 >= de.regval2;
      `JAL_I:  br_taken = 1'b1;
      `JALR_I: begin
        br_taken  = 1'b1;
        br_target = (de.regval1 + de.sxt_imm) & ~32'd1;
      end
      default: br_taken = 1'b0;
    endcase
  end

  assign br_cond = !bubble && br_taken;
  assign rd_agex = (bubble || !de.wr_reg) ? '0 : de.rd;

`ifdef AGEX_MUL_ITERATIVE_EN
  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;
  localparam int unsigned CntW = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(MUL_STEPS - 1);

  state_e            state_q, state_d;
  logic [`DBITS-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  // Multiplier FSM and shift-add datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next state, one shift-add step per RUN cycle, busy while the product is in flight
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (is_mul) begin
          mcand_d  = a;
          mplier_d = b;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = StRun;
          busy     = 1'b1;
        end
      end
      StRun: begin
        busy = 1'b1;
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LastCnt) state_d = StDone;
      end
      // The MUL still at the input is the finished one; retire it, do not restart.
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign mul_res     = acc_q;
  assign mul_pending = is_mul && (state_q != StDone);
`else
  assign mul_res     = a * b;
  assign mul_pending = 1'b0;
  assign busy        = 1'b0;
`endif

  // Next latch contents: bubbles and in-flight MULs become all-zero
  always_comb begin
    latch_d = '0;
    if (!bubble && !mul_pending) begin
      latch_d.inst       = de.inst;
      latch_d.pc         = de.pc;
      latch_d.op_i       = de.op_i;
      latch_d.inst_count = de.inst_count;
      latch_d.aluout     = aluout;
      latch_d.st_data    = de.regval2;
      latch_d.rd         = de.rd;
      latch_d.wr_reg     = de.wr_reg;
      latch_d.type_i     = de.type_i;
      latch_d.bus_canary = de.bus_canary;
    end
  end

  // AGEX -> MEM pipeline latch
  always_ff @(posedge clk) begin
    if (reset) latch_q <= '0;
    else       latch_q <= latch_d;
  end

  // Outputs are forced quiet while reset is held
  assign from_AGEX_to_DE = reset ? '0 : {rd_agex, de.type_i, br_cond, busy};
  assign from_AGEX_to_FE = reset ? '0 : {br_cond, br_target};
  assign AGEX_latch_out  = reset ? '0 : latch_q;

endmodule

// File: tb/tb_agex_stage.sv
// Randomized self-checking bench for agex_stage against a behavioural model.

`ifndef AGEX_DEFS
`define AGEX_DEFS
`define DBITS       32
`define INSTBITS    32
`define CNTBITS     32
`define REGNOBITS   5
`define TYPENOBITS  3
`define OPNOBITS    6
`define CANARYBITS  4
`define DE_latch_WIDTH (`INSTBITS + 2*`DBITS + `OPNOBITS + `CNTBITS + 3*`DBITS + `REGNOBITS + 1 + `TYPENOBITS + `CANARYBITS)
`define AGEX_latch_WIDTH (`INSTBITS + `DBITS + `OPNOBITS + `CNTBITS + 2*`DBITS + `REGNOBITS + 1 + `TYPENOBITS + `CANARYBITS)
`define from_AGEX_to_DE_WIDTH (`REGNOBITS + `TYPENOBITS + 2)
`define from_AGEX_to_FE_WIDTH (1 + `DBITS)
`define INVALID_I 6'd0
`define ADD_I     6'd1
`define ADDI_I    6'd2
`define SUB_I     6'd3
`define AND_I     6'd4
`define ANDI_I    6'd5
`define OR_I      6'd6
`define ORI_I     6'd7
`define XOR_I     6'd8
`define XORI_I    6'd9
`define SLT_I     6'd10
`define SLTI_I    6'd11
`define SLTU_I    6'd12
`define SLTIU_I   6'd13
`define SLL_I     6'd14
`define SLLI_I    6'd15
`define SRL_I     6'd16
`define SRLI_I    6'd17
`define SRA_I     6'd18
`define SRAI_I    6'd19
`define MUL_I     6'd20
`define LUI_I     6'd21
`define AUIPC_I   6'd22
`define LW_I      6'd23
`define SW_I      6'd24
`define JAL_I     6'd25
`define JALR_I    6'd26
`define BEQ_I     6'd27
`define BNE_I     6'd28
`define BLT_I     6'd29
`define BGE_I     6'd30
`define BLTU_I    6'd31
`define BGEU_I    6'd32
`define CSRR_I    6'd33
`define CSRW_I    6'd34
`define R_TYPE    3'd1
`define I_TYPE    3'd2
`define S_TYPE    3'd3
`define B_TYPE    3'd4
`define U_TYPE    3'd5
`define J_TYPE    3'd6
`endif

module tb_agex_stage;

  localparam int unsigned Steps = 32;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pcplus;
    logic [5:0]  op;
    logic [31:0] cnt;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        wr;
    logic [2:0]  ty;
    logic [3:0]  can;
  } de_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [5:0]  op;
    logic [31:0] cnt;
    logic [31:0] alu;
    logic [31:0] st;
    logic [4:0]  rd;
    logic        wr;
    logic [2:0]  ty;
    logic [3:0]  can;
  } ag_t;

  logic clk = 1'b0;
  logic reset;
  de_t  de;
  ag_t  lat;
  logic [`from_AGEX_to_DE_WIDTH-1:0] to_de;
  logic [`from_AGEX_to_FE_WIDTH-1:0] to_fe;

  int n_err = 0;
  int n_chk = 0;

  agex_stage #(.MUL_STEPS(Steps)) dut (
    .clk             (clk),
    .reset           (reset),
    .from_DE_latch   (de),
    .from_AGEX_to_DE (to_de),
    .from_AGEX_to_FE (to_fe),
    .AGEX_latch_out  (lat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic m_bubble(input de_t d);
    return (d.inst == 32'd0) || (d.op == `INVALID_I);
  endfunction

  function automatic logic [2:0] m_type(input logic [5:0] op);
    case (op)
      `ADD_I, `SUB_I, `AND_I, `OR_I, `XOR_I, `SLT_I, `SLTU_I,
      `SLL_I, `SRL_I, `SRA_I, `MUL_I:                  return `R_TYPE;
      `SW_I:                                           return `S_TYPE;
      `BEQ_I, `BNE_I, `BLT_I, `BGE_I, `BLTU_I, `BGEU_I: return `B_TYPE;
      `LUI_I, `AUIPC_I:                                return `U_TYPE;
      `JAL_I:                                          return `J_TYPE;
      default:                                         return `I_TYPE;
    endcase
  endfunction

  function automatic logic [31:0] m_alu(input de_t d);
    logic [31:0] b;
    logic [63:0] p;
    int sa, sb;
    b  = (d.ty == `R_TYPE) ? d.r2 : d.imm;
    p  = {32'd0, d.r1} * {32'd0, b};
    sa = d.r1;
    sb = b;
    case (d.op)
      `ADD_I, `ADDI_I:   return d.r1 + b;
      `SUB_I:            return d.r1 - b;
      `AND_I, `ANDI_I:   return d.r1 & b;
      `OR_I, `ORI_I:     return d.r1 | b;
      `XOR_I, `XORI_I:   return d.r1 ^ b;
      `SLT_I, `SLTI_I:   return (sa < sb) ? 32'd1 : 32'd0;
      `SLTU_I, `SLTIU_I: return (d.r1 < b) ? 32'd1 : 32'd0;
      `SLL_I, `SLLI_I:   return d.r1 << (b % 32);
      `SRL_I, `SRLI_I:   return d.r1 >> (b % 32);
      `SRA_I, `SRAI_I:   return sa >>> (b % 32);
      `MUL_I:            return p[31:0];
      `LUI_I:            return d.imm;
      `AUIPC_I:          return d.pc + d.imm;
      `LW_I, `SW_I:      return d.r1 + d.imm;
      `JAL_I, `JALR_I:   return d.pcplus;
      `CSRR_I, `CSRW_I:  return d.r1;
      default:           return 32'd0;
    endcase
  endfunction

  function automatic logic m_taken(input de_t d);
    int sa, sb;
    sa = d.r1;
    sb = d.r2;
    if (m_bubble(d)) return 1'b0;
    case (d.op)
      `BEQ_I:          return d.r1 == d.r2;
      `BNE_I:          return d.r1 != d.r2;
      `BLT_I:          return sa < sb;
      `BGE_I:          return sa >= sb;
      `BLTU_I:         return d.r1 < d.r2;
      `BGEU_I:         return d.r1 >= d.r2;
      `JAL_I, `JALR_I: return 1'b1;
      default:         return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_target(input de_t d);
    if (d.op == `JALR_I) return (d.r1 + d.imm) & 32'hFFFF_FFFE;
    return d.pc + d.imm;
  endfunction

  function automatic ag_t m_latch(input de_t d);
    ag_t e;
    e = '0;
    if (!m_bubble(d)) begin
      e.inst = d.inst; e.pc = d.pc; e.op = d.op; e.cnt = d.cnt;
      e.alu = m_alu(d); e.st = d.r2; e.rd = d.rd; e.wr = d.wr;
      e.ty = d.ty; e.can = d.can;
    end
    return e;
  endfunction

  function automatic de_t mk(input logic [5:0] op, input logic [31:0] r1, input logic [31:0] r2,
                             input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] rd);
    de_t d;
    d.inst = $urandom | 32'd1;
    d.pc = pc; d.pcplus = pc + 32'd4; d.op = op; d.cnt = $urandom;
    d.r1 = r1; d.r2 = r2; d.imm = imm; d.rd = rd; d.wr = 1'b1;
    d.ty = m_type(op); d.can = 4'hA;
    return d;
  endfunction

  function automatic de_t rand_de();
    de_t d;
    logic [5:0] op;
    int k;
    op = 6'($urandom_range(1, 34));
`ifdef AGEX_MUL_ITERATIVE_EN
    if (op == `MUL_I) op = `ADD_I;
`endif
    d = mk(op, $urandom, $urandom, $urandom, $urandom & 32'hFFFF_FFFC, 5'($urandom));
    if ($urandom_range(3) == 0) d.r2 = d.r1;
    if ($urandom_range(3) == 0) d.r1 = 32'($urandom_range(0, 40));
    d.wr  = 1'($urandom);
    d.can = 4'($urandom);
    k = $urandom_range(19);
    if (k == 0) d.inst = 32'd0;
    if (k == 1) d.op = `INVALID_I;
    return d;
  endfunction

  // Drive one instruction, check the combinational side, then the latch after the edge.
  task automatic apply(input de_t d);
    ag_t e;
    de = d;
    #1;
    check("br_cond", to_fe[32], m_taken(d));
    if (m_taken(d)) check("br_target", to_fe[31:0], m_target(d));
    check("rd_agex", to_de[9:5], (m_bubble(d) || !d.wr) ? 5'd0 : d.rd);
    check("type_agex", to_de[4:2], d.ty);
    check("de_br_cond", to_de[1], m_taken(d));
    check("busy", to_de[0], 1'b0);
    e = m_latch(d);
    @(posedge clk);
    #1;
    check("latch", lat, e);
  endtask

`ifdef AGEX_MUL_ITERATIVE_EN
  task automatic mul_iter(input logic [31:0] x, input logic [31:0] y, input logic [31:0] prod);
    int cycles;
    de = mk(`MUL_I, x, y, 32'd0, 32'h200, 5'd9);
    #1;
    cycles = 0;
    while (to_de[0] && cycles < 100) begin
      cycles++;
      if (cycles == 5) begin
        check("mul_latch_bubble", lat, '0);
        check("mul_rd_agex", to_de[9:5], 5'd9);
        check("mul_br_cond", to_fe[32], 1'b0);
      end
      @(posedge clk);
      #1;
    end
    check("mul_busy_cycles", cycles, Steps + 1);
    @(posedge clk);
    #1;
    check("mul_result", lat.alu, prod);
    check("mul_rd", lat.rd, 5'd9);
    de = '0;
    @(posedge clk);
    #1;
  endtask
`endif

  initial begin
    de_t d;
    // Reset: outputs quiet while held, latch zero afterwards
    reset = 1'b1;
    de = mk(`JAL_I, 32'd1, 32'd2, 32'h10, 32'h80, 5'd3);
    #2;
    check("rst_to_de", to_de, '0);
    check("rst_to_fe", to_fe, '0);
    check("rst_latch", lat, '0);
    @(posedge clk);
    #1;
    de = '0;
    reset = 1'b0;
    #1;
    check("post_rst_latch", lat, '0);

    // ADD with wrap-around
    d = mk(`ADD_I, 32'd7, 32'hFFFF_FFFB, 32'd0, 32'h100, 5'd5);
    de = d;
    #1;
    check("t1_rd_agex", to_de[9:5], 5'd5);
    apply(d);
    check("t1_alu", lat.alu, 32'd2);
    check("t1_rd", lat.rd, 5'd5);
    check("t1_wr", lat.wr, 1'b1);

    // BLT taken, BLTU not taken with the same operands
    d = mk(`BLT_I, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF0, 32'h100, 5'd0);
    de = d;
    #1;
    check("t2_blt_br", to_fe[32], 1'b1);
    check("t2_blt_tgt", to_fe[31:0], 32'hF0);
    apply(d);
    d.op = `BLTU_I;
    de = d;
    #1;
    check("t2_bltu_br", to_fe[32], 1'b0);
    apply(d);

    // JALR clears bit 0 of the target and links pcplus
    d = mk(`JALR_I, 32'h203, 32'd0, 32'd0, 32'h40, 5'd1);
    de = d;
    #1;
    check("t3_tgt", to_fe[31:0], 32'h202);
    check("t3_br", to_fe[32], 1'b1);
    apply(d);
    check("t3_alu", lat.alu, 32'h44);

    // Three bubble cycles
    for (int i = 0; i < 3; i++) begin
      d = rand_de();
      d.inst = 32'd0;
      de = d;
      #1;
      check("t4_br", to_fe[32], 1'b0);
      check("t4_rd_agex", to_de[9:5], 5'd0);
      @(posedge clk);
      #1;
      check("t4_latch", lat, '0);
    end

    // Multiply
`ifdef AGEX_MUL_ITERATIVE_EN
    mul_iter(32'h0001_0003, 32'h0000_0005, 32'h0005_000F);
    // Reset mid-RUN at cnt=10
    de = mk(`MUL_I, 32'h1234_5678, 32'h9ABC_DEF1, 32'd0, 32'h300, 5'd4);
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    check("t6_busy_before", to_de[0], 1'b1);
    reset = 1'b1;
    de = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("t6_busy_after", to_de[0], 1'b0);
    check("t6_latch", lat, '0);
    mul_iter(32'd7, 32'd6, 32'd42);
`else
    d = mk(`MUL_I, 32'h0001_0003, 32'h0000_0005, 32'd0, 32'h200, 5'd9);
    apply(d);
    check("t5_mul", lat.alu, 32'h0005_000F);
    reset = 1'b1;
    de = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("t6_latch", lat, '0);
    apply(mk(`MUL_I, 32'd7, 32'd6, 32'd0, 32'h204, 5'd2));
    check("t6_mul", lat.alu, 32'd42);
`endif

    // Randomized stream against the model
    for (int i = 0; i < 400; i++) apply(rand_de());

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
